// File: rtl/vbus_arb_pkg.sv
// vbus_arb_pkg: shared types and constants for the 68k external-bus arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - owner_t     : bus owner code (CPU / DMA / Z80)
//   - TMR_W       : width of the shared grant-timeout / release-hold timer
//   - pick_winner : round-robin choice between the two alternate masters
package vbus_arb_pkg;

   localparam int TMR_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_ACQ     = 3'd2,
      ST_OWN     = 3'd3,
      ST_REL     = 3'd4,
      ST_BACKOFF = 3'd5
   } arb_state_e;

   typedef logic [1:0] owner_t;

   localparam owner_t OWN_CPU = 2'd0;
   localparam owner_t OWN_DMA = 2'd1;
   localparam owner_t OWN_Z80 = 2'd2;

   // On a tie the master that did not own the bus last time wins.
   function automatic owner_t pick_winner(input logic dma, input logic z80,
                                          input owner_t last);
      if (dma && z80) return (last == OWN_DMA) ? OWN_Z80 : OWN_DMA;
      if (dma)        return OWN_DMA;
      if (z80)        return OWN_Z80;
      return OWN_CPU;
   endfunction

endpackage

// File: rtl/vbus_arbiter_if.sv
// vbus_arbiter_if: request/grant and 68k bus-handshake signals of the arbiter.
//   slave  modport : arbiter side (takes requests and 68k lines, drives grants/pulls)
//   master modport : requester / environment side
interface vbus_arbiter_if;
   import vbus_arb_pkg::*;

   logic   dma_req;
   logic   dma_gnt;
   logic   z80_req;
   logic   z80_gnt;
   logic   z80_wait;
   logic   BG;
   logic   AS_i;
   logic   BGACK_i;
   logic   BR_pull;
   logic   BGACK_pull;
   owner_t owner;
   logic   timeout;

   modport slave (
      input  dma_req, z80_req, BG, AS_i, BGACK_i,
      output dma_gnt, z80_gnt, z80_wait, BR_pull, BGACK_pull, owner, timeout
   );

   modport master (
      output dma_req, z80_req, BG, AS_i, BGACK_i,
      input  dma_gnt, z80_gnt, z80_wait, BR_pull, BGACK_pull, owner, timeout
   );
endinterface

// File: rtl/vbus_arb_timer.sv
// vbus_arb_timer: shared up/down counter used for both the bus-grant timeout
// (counts up) and the post-release BGACK hold (counts down).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   tick_i        : clock enable; the counter only moves on ticks
//   load_i        : load load_val_i (has priority over counting)
//   up_i / dn_i   : count up / down by one
//   term_val_i    : terminal value to compare against
//   term_o        : count equals term_val_i
module vbus_arb_timer
   import vbus_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   input  logic             up_i,
   input  logic             dn_i,
   input  logic [TMR_W-1:0] term_val_i,
   output logic             term_o
);

   logic [TMR_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (tick_i) begin
         if (load_i)    cnt_q <= load_val_i;
         else if (up_i) cnt_q <= cnt_q + 1'b1;
         else if (dn_i) cnt_q <= cnt_q - 1'b1;
      end
   end

   assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/vbus_arbiter.sv
// vbus_arbiter: acquires the 68k external bus (BR -> BG -> BGACK) and hands it
// to one of two alternate masters (VDP DMA, Z80 bank window), round-robin on ties.
//   MCLK    : system clock
//   RESET   : synchronous, active-high reset
//   MCLK_e  : clock enable; state only changes on enabled edges ("ticks")
//   bus     : requests, grants, z80_wait, BG/AS/BGACK sense, BR/BGACK pulls,
//             owner code and one-tick timeout pulse
//
// state   | meaning
// IDLE    | bus belongs to the 68k, nothing pending
// REQ     | BR driven, waiting for BG with bus idle (AS and BGACK high)
// ACQ     | BGACK held, choosing the next owner
// OWN     | one master holds its grant
// REL     | BGACK still held for a short hold time after the last owner
// BACKOFF | one tick with BR released after a grant timeout
module vbus_arbiter
   import vbus_arb_pkg::*;
#(
   parameter int BG_TIMEOUT = 255,
   parameter int REL_HOLD   = 2
) (
   input  logic          MCLK,
   input  logic          RESET,
   input  logic          MCLK_e,
   vbus_arbiter_if.slave bus
);

   localparam logic [TMR_W-1:0] TO_TERM  = TMR_W'(BG_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] REL_LOAD = TMR_W'(REL_HOLD);

   arb_state_e       state_q, state_d;
   owner_t           own_q, own_d;
   owner_t           last_q, last_d;
   owner_t           win;
   logic             timeout_d;
   logic             br_q, bgack_q, dma_gnt_q, z80_gnt_q, timeout_q;
   logic             any_req, grant_ok, own_req, other_req;
   logic             tmr_load, tmr_up, tmr_dn, tmr_term;
   logic [TMR_W-1:0] tmr_load_val, tmr_term_val;

   assign any_req   = bus.dma_req | bus.z80_req;
   assign grant_ok  = ~bus.BG & bus.AS_i & bus.BGACK_i;
   assign own_req   = (own_q == OWN_DMA) ? bus.dma_req : bus.z80_req;
   assign other_req = (own_q == OWN_DMA) ? bus.z80_req : bus.dma_req;
   assign win       = pick_winner(bus.dma_req, bus.z80_req, last_q);

   // The single timer serves REQ (count up to the timeout) and REL (count down to 0).
   assign tmr_term_val = (state_q == ST_REQ) ? TO_TERM : '0;

   vbus_arb_timer u_tmr (
      .clk_i      (MCLK),
      .rst_i      (RESET),
      .tick_i     (MCLK_e),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .up_i       (tmr_up),
      .dn_i       (tmr_dn),
      .term_val_i (tmr_term_val),
      .term_o     (tmr_term)
   );

   always_comb begin
      state_d      = state_q;
      own_d        = own_q;
      last_d       = last_q;
      timeout_d    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_up       = 1'b0;
      tmr_dn       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_REQ;
               tmr_load = 1'b1;
            end
         end
         ST_REQ: begin
            // Grant wins over a dropped request and over the timeout.
            if (grant_ok) begin
               state_d = ST_ACQ;
            end else if (!any_req) begin
               state_d = ST_IDLE;
            end else if (tmr_term) begin
               state_d   = ST_BACKOFF;
               timeout_d = 1'b1;
            end else begin
               tmr_up = 1'b1;
            end
         end
         ST_BACKOFF: state_d = ST_IDLE;
         ST_ACQ: begin
            if (win != OWN_CPU) begin
               state_d = ST_OWN;
               own_d   = win;
               last_d  = win;
            end else begin
               state_d      = ST_REL;
               tmr_load     = 1'b1;
               tmr_load_val = REL_LOAD;
            end
         end
         ST_OWN: begin
            if (!own_req) begin
               own_d = OWN_CPU;
               if (other_req) begin
                  state_d = ST_ACQ;
               end else begin
                  state_d      = ST_REL;
                  tmr_load     = 1'b1;
                  tmr_load_val = REL_LOAD;
               end
            end
         end
         ST_REL: begin
            if (any_req)       state_d = ST_ACQ;
            else if (tmr_term) state_d = ST_IDLE;
            else               tmr_dn  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered as a decode of the next state so they line up
   // with the state they describe.
   always_ff @(posedge MCLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         own_q     <= OWN_CPU;
         last_q    <= OWN_Z80;
         br_q      <= 1'b0;
         bgack_q   <= 1'b0;
         dma_gnt_q <= 1'b0;
         z80_gnt_q <= 1'b0;
         timeout_q <= 1'b0;
      end else if (MCLK_e) begin
         state_q   <= state_d;
         own_q     <= own_d;
         last_q    <= last_d;
         br_q      <= (state_d == ST_REQ);
         bgack_q   <= (state_d == ST_ACQ) || (state_d == ST_OWN) || (state_d == ST_REL);
         dma_gnt_q <= (own_d == OWN_DMA);
         z80_gnt_q <= (own_d == OWN_Z80);
         timeout_q <= timeout_d;
      end
   end

   assign bus.dma_gnt    = dma_gnt_q;
   assign bus.z80_gnt    = z80_gnt_q;
   assign bus.z80_wait   = bus.z80_req & ~z80_gnt_q;
   assign bus.BR_pull    = br_q;
   assign bus.BGACK_pull = bgack_q;
   assign bus.owner      = own_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_vbus_arbiter.sv
module tb_vbus_arbiter;

   localparam int BG_TO = 8;
   localparam int REL_H = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   vbus_arbiter_if bus();

   vbus_arbiter #(.BG_TIMEOUT(BG_TO), .REL_HOLD(REL_H)) dut (
      .MCLK   (clk),
      .RESET  (rst),
      .MCLK_e (ce),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bus phase flags rather than a state code.
   int m_br, m_ack, m_own, m_pick, m_rel, m_backoff, m_to, m_wait, m_last;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_br = 0; m_ack = 0; m_own = 0; m_pick = 0; m_rel = 0;
      m_backoff = 0; m_to = 0; m_wait = 0; m_last = 2;
   endtask

   task automatic model_tick(input bit dr, input bit zr, input bit grant);
      bit any;
      bit other;
      int win;
      any  = dr | zr;
      m_to = 0;
      if (m_backoff != 0) begin
         m_backoff = 0;
      end else if (m_br != 0) begin
         if (grant) begin
            m_br = 0; m_ack = 1; m_pick = 1;
         end else if (!any) begin
            m_br = 0;
         end else if (m_wait == BG_TO - 1) begin
            m_br = 0; m_backoff = 1; m_to = 1;
         end else begin
            m_wait++;
         end
      end else if (m_ack != 0) begin
         if (m_own != 0) begin
            if (!((m_own == 1) ? dr : zr)) begin
               other = (m_own == 1) ? zr : dr;
               m_own = 0;
               if (other) m_pick = 1;
               else       m_rel  = REL_H;
            end
         end else if (m_pick != 0) begin
            m_pick = 0;
            if (dr && zr)  win = (m_last == 1) ? 2 : 1;
            else if (dr)   win = 1;
            else if (zr)   win = 2;
            else           win = 0;
            if (win != 0) begin
               m_own = win; m_last = win;
            end else begin
               m_rel = REL_H;
            end
         end else begin
            if (any)             m_pick = 1;
            else if (m_rel == 0) m_ack  = 0;
            else                 m_rel--;
         end
      end else if (any) begin
         m_br = 1; m_wait = 0;
      end
   endtask

   // One clock: drive at negedge, advance model on the edge, compare at next negedge.
   task automatic cyc(input bit e, input bit dr, input bit zr, input bit bg,
                      input bit as_n, input bit bga, input bit r);
      ce = e; rst = r;
      bus.dma_req = dr; bus.z80_req = zr;
      bus.BG = bg; bus.AS_i = as_n; bus.BGACK_i = bga;
      @(posedge clk);
      if (r)      model_reset();
      else if (e) model_tick(dr, zr, !bg && as_n && bga);
      @(negedge clk);
      check_val("br",       32'(bus.BR_pull),    32'(m_br));
      check_val("bgack",    32'(bus.BGACK_pull), 32'(m_ack));
      check_val("dma_gnt",  32'(bus.dma_gnt),    32'(m_own == 1));
      check_val("z80_gnt",  32'(bus.z80_gnt),    32'(m_own == 2));
      check_val("owner",    32'(bus.owner),      32'(m_own));
      check_val("timeout",  32'(bus.timeout),    32'(m_to));
      check_val("z80_wait", 32'(bus.z80_wait),   32'(zr && (m_own != 2)));
      check_val("inv_gnt2", 32'(bus.dma_gnt & bus.z80_gnt), 32'd0);
      check_val("inv_gack", 32'((bus.dma_gnt | bus.z80_gnt) & ~bus.BGACK_pull), 32'd0);
      check_val("inv_pull", 32'(bus.BR_pull & bus.BGACK_pull), 32'd0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      int  tcount;
      int  tfirst;
      logic [15:0] br_hist;
      bit  dr, zr, bg, asn, bga, e, r;

      bus.dma_req = 1'b0; bus.z80_req = 1'b0;
      bus.BG = 1'b1; bus.AS_i = 1'b1; bus.BGACK_i = 1'b1;
      model_reset();
      @(negedge clk);

      // Reset state
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_val("rst_owner", 32'(bus.owner), 32'd0);
      idle_cycles(2);

      // Basic DMA acquisition and release hold
      cyc(1, 1, 0, 1, 1, 1, 0);
      check_val("t1_br_on", 32'(bus.BR_pull), 32'd1);
      cyc(1, 1, 0, 1, 1, 1, 0);
      cyc(1, 1, 0, 1, 1, 1, 0);
      check_val("t1_br_t3", 32'(bus.BR_pull), 32'd1);
      cyc(1, 1, 0, 0, 1, 1, 0);
      check_val("t1_bgack", 32'(bus.BGACK_pull), 32'd1);
      check_val("t1_br_off", 32'(bus.BR_pull), 32'd0);
      cyc(1, 1, 0, 0, 1, 1, 0);
      check_val("t1_dma_gnt", 32'(bus.dma_gnt), 32'd1);
      check_val("t1_owner", 32'(bus.owner), 32'd1);
      repeat (3) cyc(1, 1, 0, 1, 1, 1, 0);
      cyc(1, 0, 0, 1, 1, 1, 0);
      check_val("t1_gnt_drop", 32'(bus.dma_gnt), 32'd0);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 0, 0, 1, 1, 1, 0);
         check_val("t1_hold", 32'(bus.BGACK_pull), 32'd1);
      end
      cyc(1, 0, 0, 1, 1, 1, 0);
      check_val("t1_release", 32'(bus.BGACK_pull), 32'd0);
      idle_cycles(2);

      // AS gating
      cyc(1, 1, 0, 1, 1, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 0, 0, 0, 1, 0);
         check_val("t2_as_low", 32'(bus.BGACK_pull), 32'd0);
      end
      cyc(1, 1, 0, 0, 1, 1, 0);
      check_val("t2_as_high", 32'(bus.BGACK_pull), 32'd1);
      cyc(1, 1, 0, 1, 1, 1, 0);
      cyc(1, 0, 0, 1, 1, 1, 0);
      idle_cycles(5);

      // Grant timeout and back-off
      tcount = 0; tfirst = -1; br_hist = '0;
      for (int k = 0; k < 14; k++) begin
         cyc(1, 1, 0, 1, 1, 1, 0);
         br_hist[k] = bus.BR_pull;
         if (bus.timeout) begin
            tcount++;
            if (tfirst < 0) tfirst = k;
         end
      end
      check_val("t3_to_count", 32'(tcount), 32'd1);
      check_val("t3_to_tick", 32'(tfirst), 32'd8);
      check_val("t3_br_pre", 32'(br_hist[7]), 32'd1);
      check_val("t3_br_off1", 32'(br_hist[8]), 32'd0);
      check_val("t3_br_off2", 32'(br_hist[9]), 32'd0);
      check_val("t3_br_retry", 32'(br_hist[10]), 32'd1);
      cyc(1, 0, 0, 1, 1, 1, 0);
      idle_cycles(2);

      // Simultaneous requests after reset: DMA first, then Z80 with no release
      repeat (2) cyc(1, 0, 0, 1, 1, 1, 1);
      cyc(1, 1, 1, 0, 1, 1, 0);
      check_val("t4_wait0", 32'(bus.z80_wait), 32'd1);
      cyc(1, 1, 1, 0, 1, 1, 0);
      cyc(1, 1, 1, 0, 1, 1, 0);
      check_val("t4_dma_first", 32'(bus.dma_gnt), 32'd1);
      check_val("t4_wait_own", 32'(bus.z80_wait), 32'd1);
      repeat (2) cyc(1, 1, 1, 0, 1, 1, 0);
      cyc(1, 0, 1, 0, 1, 1, 0);
      check_val("t4_gap_dma", 32'(bus.dma_gnt), 32'd0);
      check_val("t4_gap_z80", 32'(bus.z80_gnt), 32'd0);
      check_val("t4_gap_bgack", 32'(bus.BGACK_pull), 32'd1);
      check_val("t4_gap_wait", 32'(bus.z80_wait), 32'd1);
      cyc(1, 0, 1, 0, 1, 1, 0);
      check_val("t4_z80_gnt", 32'(bus.z80_gnt), 32'd1);
      check_val("t4_owner", 32'(bus.owner), 32'd2);
      check_val("t4_wait_off", 32'(bus.z80_wait), 32'd0);

      // Re-request during release hold
      cyc(1, 0, 0, 1, 1, 1, 0);
      check_val("t5_rel_bgack", 32'(bus.BGACK_pull), 32'd1);
      cyc(1, 0, 1, 1, 1, 1, 0);
      check_val("t5_acq_br", 32'(bus.BR_pull), 32'd0);
      check_val("t5_acq_bgack", 32'(bus.BGACK_pull), 32'd1);
      cyc(1, 0, 1, 1, 1, 1, 0);
      check_val("t5_z80_gnt", 32'(bus.z80_gnt), 32'd1);
      check_val("t5_br", 32'(bus.BR_pull), 32'd0);

      // Reset while owning, then clock-enable freeze
      cyc(1, 0, 1, 1, 1, 1, 1);
      check_val("t6_rst_gnt", 32'(bus.z80_gnt), 32'd0);
      check_val("t6_rst_bgack", 32'(bus.BGACK_pull), 32'd0);
      check_val("t6_rst_wait", 32'(bus.z80_wait), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1, 0, 1, 1, 0);
         check_val("t6_frz_br", 32'(bus.BR_pull), 32'd0);
      end
      cyc(1, 1, 1, 1, 1, 1, 0);
      check_val("t6_tick_br", 32'(bus.BR_pull), 32'd1);
      cyc(1, 0, 0, 1, 1, 1, 0);
      idle_cycles(2);

      // Randomized traffic against the model
      dr = 0; zr = 0; bg = 1; asn = 1; bga = 1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(15, 0) == 0) dr  = ~dr;
         if ($urandom_range(15, 0) == 0) zr  = ~zr;
         if ($urandom_range(3, 0)  == 0) bg  = ~bg;
         if ($urandom_range(7, 0)  == 0) asn = ~asn;
         bga = ($urandom_range(9, 0) != 0);
         e   = ($urandom_range(3, 0) != 0);
         r   = ($urandom_range(299, 0) == 0);
         cyc(e, dr, zr, bg, asn, bga, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vbus_arbiter.md
Name: vbus_arbiter

Overview:
- Sequences ownership of the shared 68k external bus (VA/VD/strobes) between two alternate masters: VDP DMA and the Z80 bank window.
- Runs the 68k bus-request handshake: BR, then wait for BG, then assert BGACK.
- Hands the acquired bus to exactly one requester at a time, using round-robin on ties.
- Sits in the top-level integration next to the bus-arbiter logic; the open-drain BR/BGACK pulls are ANDed into the existing pull network.

Parameters:
- BG_TIMEOUT, 255: ticks to wait in REQ for the bus grant before backing off. Legal range 2..1023; timer width 10 bits.
- REL_HOLD, 2: ticks BGACK stays asserted after the last owner releases. Legal range 1..15.

Ports:
- MCLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- MCLK_e  in  1  clock enable; a "tick" is an MCLK edge with MCLK_e=1; state changes only on ticks
- dma_req  in  1  VDP DMA requests the bus; level, held until done
- dma_gnt  out  1  DMA owns the bus
- z80_req  in  1  Z80 bank access requests the bus; level
- z80_gnt  out  1  Z80 owns the bus
- z80_wait  out  1  stall the Z80; = z80_req & ~z80_gnt (combinational from registered z80_gnt)
- BG  in  1  68k bus grant, active low
- AS_i  in  1  68k address strobe, active low
- BGACK_i  in  1  sensed BGACK line, active low
- BR_pull  out  1  drive BR low when 1
- BGACK_pull  out  1  drive BGACK low when 1
- owner  out  2  0 = CPU, 1 = DMA, 2 = Z80; 3 never driven
- timeout  out  1  one-tick pulse on grant timeout

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, last_owner 2 (so DMA wins the first tie). Reset mid-operation drops BR_pull, BGACK_pull and both grants on the same edge; no release hold.
- All outputs are registered except z80_wait. Non-tick edges hold state.
- States: IDLE, REQ, ACQ, OWN, REL, BACKOFF.
- IDLE:
  - any req=1 at a tick -> REQ; BR_pull=1; timer=0.
- REQ:
  - Grant condition is BG=0 & AS_i=1 & BGACK_i=1, sampled at a tick. When met -> ACQ; BR_pull=0; BGACK_pull=1.
  - If both reqs are 0 (and the grant condition is not met) -> IDLE; BR_pull=0.
  - Otherwise timer++. On the tick where timer==BG_TIMEOUT-1 -> BACKOFF; BR_pull=0; timeout=1 for that tick.
  - Grant has priority over both timeout and req-drop on the same tick.
- BACKOFF: one tick, then IDLE. The request is retried from IDLE if still pending.
- ACQ (BGACK held, no grant):
  - Winner: the only pending requester, or on tie the requester != last_owner.
  - Winner exists -> OWN; set the winner's gnt, owner and last_owner.
  - No requester pending -> REL.
  - Latency from the REQ grant tick to gnt visible: 2 ticks.
- OWN:
  - gnt held while the owner's req=1.
  - Owner's req=0 at a tick -> gnt=0, owner=0, then:
    - other requester pending -> ACQ (one-tick gap; bus not released);
    - else -> REL with hold counter=REL_HOLD.
  - The other req rising during OWN is ignored until release; no preemption.
- REL:
  - Counter decrements each tick; at 0 -> BGACK_pull=0 -> IDLE.
  - Any req=1 during REL -> ACQ immediately (BGACK stays asserted, no new BR).
- Invariants:
  - dma_gnt & z80_gnt never both 1.
  - gnt is never 1 unless BGACK_pull=1.
  - BR_pull and BGACK_pull are never both 1.

Decomposition:
- Shared package vbus_arb_pkg holds:
  - state encoding (IDLE=0, REQ=1, ACQ=2, OWN=3, REL=4, BACKOFF=5);
  - owner codes OWN_CPU=0, OWN_DMA=1, OWN_Z80=2;
  - timer width constant 10.
- One sub-module: vbus_arb_timer, a shared down/up counter with load, enable (tick) and terminal flag. It is used for both the grant timeout and the release hold.

Test Plan:
- Basic DMA acquisition: dma_req=1 at tick 0, BG=0 from tick 3, AS_i=1, BGACK_i=1:
  - BR_pull=1 at ticks 1–3;
  - BGACK_pull=1 from tick 4;
  - dma_gnt=1 and owner=1 from tick 5.
  - Then drop dma_req -> gnt=0 next tick; BGACK_pull falls REL_HOLD(2)+1 ticks later.
- AS_i gating: hold AS_i=0 for 4 ticks after BG=0 -> BGACK_pull stays 0 until the tick after AS_i rises.
- Simultaneous requests after reset:
  - DMA granted first;
  - DMA drops -> one-tick gap -> z80_gnt=1 with no BGACK release;
  - z80_wait=1 for the whole interval before z80_gnt.
- Timeout: BG held 1 with BG_TIMEOUT=8 -> timeout pulses exactly once on tick 8 after BR; BR_pull=0 for 2 ticks; then BR reasserts.
- Re-request during REL: z80_req rises 1 tick after the DMA release -> z80_gnt within 2 ticks; BGACK_pull never drops; BR_pull never reasserts.
- RESET=1 while in OWN: all outputs 0 at the next edge; state IDLE; z80_wait follows z80_req; MCLK_e=0 ticks freeze all outputs.
